// File: rtl/led_pattern_ctrl_pkg.sv
// Shared constants for the LED sequencer: mode codes, debounce states, start patterns.
package led_pattern_ctrl_pkg;
    localparam int LED_W     = 8;
    localparam int NUM_MODES = 5;

    localparam logic [2:0] MODE_BOUNCE = 3'd0;
    localparam logic [2:0] MODE_ROT_R  = 3'd1;
    localparam logic [2:0] MODE_ROT_L  = 3'd2;
    localparam logic [2:0] MODE_FILL   = 3'd3;
    localparam logic [2:0] MODE_BLINK  = 3'd4;

    typedef enum logic [1:0] {
        DEB_IDLE, DEB_PRESS_WAIT, DEB_HELD, DEB_RELEASE_WAIT
    } debStateT;

    typedef enum logic {DIR_RIGHT, DIR_LEFT} dirT;

    function automatic logic [LED_W-1:0] modeStart(input logic [2:0] m);
        case (m)
            MODE_ROT_L:            modeStart = 8'h01;
            MODE_FILL, MODE_BLINK: modeStart = 8'h00;
            default:               modeStart = 8'h80;
        endcase
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// Mode-button synchroniser and debounce FSM; one press pulse per accepted press.
module btn_debounce
    import led_pattern_ctrl_pkg::*;
#(
    parameter int DEB_CNT  = 65536,
    parameter int SYNC_STG = 2
) (
    input  logic iCLK,
    input  logic rstN,
    input  logic iMODE_BTN,
    output logic press
);
    localparam int CW = $clog2(DEB_CNT + 1);

    logic [SYNC_STG-1:0] btnSync;
    logic                btnS;
    logic [CW-1:0]       cnt;
    logic                stable;
    debStateT            state, stateNxt;

    assign btnS   = btnSync[SYNC_STG-1];
    assign stable = (cnt == CW'(DEB_CNT - 1));

    always_ff @(posedge iCLK or negedge rstN) begin
        if (!rstN) begin
            btnSync <= '0;
            state   <= DEB_IDLE;
            cnt     <= '0;
        end else begin
            btnSync <= (btnSync << 1) | SYNC_STG'(iMODE_BTN);
            state   <= stateNxt;
            if (stateNxt != state) cnt <= '0;
            else if (state == DEB_PRESS_WAIT || state == DEB_RELEASE_WAIT) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            DEB_IDLE:         if (btnS) stateNxt = DEB_PRESS_WAIT;
            DEB_PRESS_WAIT:   if (!btnS) stateNxt = DEB_IDLE;
                              else if (stable) stateNxt = DEB_HELD;
            DEB_HELD:         if (!btnS) stateNxt = DEB_RELEASE_WAIT;
            DEB_RELEASE_WAIT: if (btnS) stateNxt = DEB_HELD;
                              else if (stable) stateNxt = DEB_IDLE;
            default:          stateNxt = DEB_IDLE;
        endcase
    end

    always_comb begin
        press = (state == DEB_PRESS_WAIT) && btnS && stable;
    end
endmodule

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: period BASE_DIV >> iSPEED, frozen by the synchronised pause switch.
module led_tick_gen #(
    parameter int BASE_DIV = 524288,
    parameter int SYNC_STG = 2
) (
    input  logic       iCLK,
    input  logic       rstN,
    input  logic       iPAUSE,
    input  logic [1:0] iSPEED,
    input  logic       clr,
    output logic       tick
);
    localparam int CW = $clog2(BASE_DIV);

    logic [SYNC_STG-1:0] pauseSync;
    logic                pauseS;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       lim;

    assign pauseS = pauseSync[SYNC_STG-1];
    assign lim    = CW'((BASE_DIV >> iSPEED) - 1);
    // >= rather than == so a speed-up past the current count wraps at once
    assign tick   = !pauseS && (cnt >= lim);

    always_ff @(posedge iCLK or negedge rstN) begin
        if (!rstN) begin
            pauseSync <= '0;
            cnt       <= '0;
        end else begin
            pauseSync <= (pauseSync << 1) | SYNC_STG'(iPAUSE);
            if (clr || tick) cnt <= '0;
            else if (!pauseS) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// 8-LED pattern sequencer: mode register, pattern stepping and bounce direction.
module led_pattern_ctrl
    import led_pattern_ctrl_pkg::*;
#(
    parameter int BASE_DIV = 524288,
    parameter int DEB_CNT  = 65536,
    parameter int SYNC_STG = 2
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iMODE_BTN,
    input  logic             iPAUSE,
    input  logic [1:0]       iSPEED,
    output logic [LED_W-1:0] oLED,
    output logic [2:0]       oMODE,
    output logic             oTICK
);
    logic [1:0]       rstPipe;
    logic             rstN;
    logic             tickRaw;
    logic             press;
    logic [LED_W-1:0] led, stepLed;
    logic [2:0]       mode, nextMode;
    dirT              dir, stepDir;

    // Reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) rstPipe <= '0;
        else         rstPipe <= {rstPipe[0], 1'b1};
    end
    assign rstN = rstPipe[1];

    led_tick_gen #(.BASE_DIV(BASE_DIV), .SYNC_STG(SYNC_STG)) uTick (
        .iCLK(iCLK), .rstN(rstN), .iPAUSE(iPAUSE), .iSPEED(iSPEED),
        .clr(press), .tick(tickRaw)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT), .SYNC_STG(SYNC_STG)) uDeb (
        .iCLK(iCLK), .rstN(rstN), .iMODE_BTN(iMODE_BTN), .press(press)
    );

    assign nextMode = (mode >= 3'(NUM_MODES - 1)) ? MODE_BOUNCE : mode + 3'd1;

    always_comb begin
        stepLed = led;
        stepDir = dir;
        case (mode)
            MODE_BOUNCE:
                if (dir == DIR_LEFT) begin
                    if (led == 8'h80) begin stepLed = 8'h40; stepDir = DIR_RIGHT; end
                    else stepLed = led << 1;
                end else begin
                    if (led == 8'h01) begin stepLed = 8'h02; stepDir = DIR_LEFT; end
                    else stepLed = led >> 1;
                end
            MODE_ROT_R: stepLed = {led[0], led[LED_W-1:1]};
            MODE_ROT_L: stepLed = {led[LED_W-2:0], led[LED_W-1]};
            MODE_FILL:  stepLed = (led == 8'hFF) ? 8'h00 : {led[LED_W-2:0], 1'b1};
            MODE_BLINK: stepLed = ~led;
            default:    ;
        endcase
    end

    // Mode change outranks a coinciding tick; an upset mode code recovers to bounce
    always_ff @(posedge iCLK or negedge rstN) begin
        if (!rstN) begin
            mode <= MODE_BOUNCE;
            led  <= 8'h80;
            dir  <= DIR_RIGHT;
        end else if (mode > MODE_BLINK) begin
            mode <= MODE_BOUNCE;
            led  <= 8'h80;
            dir  <= DIR_RIGHT;
        end else if (press) begin
            mode <= nextMode;
            led  <= modeStart(nextMode);
            dir  <= DIR_RIGHT;
        end else if (tickRaw) begin
            led  <= stepLed;
            dir  <= stepDir;
        end
    end

    assign oLED  = led;
    assign oMODE = mode;
    assign oTICK = tickRaw && !press && rstN;
endmodule
